// File: rtl/fir_filter_mc.sv
// ---------------------------------------------------------------------------
// fir_filter_mc
//
// Multi-channel FIR filter built around one serial multiply-accumulate unit.
// CHANNELS independent delay lines share a single TAPS-entry coefficient
// table, which can be rewritten at runtime while the block is idle. One
// sample is accepted, filtered over TAPS MAC cycles, and its result is
// presented with a one-cycle strobe before the next sample is taken.
//
// Ports
//   clk              clock, all state on the rising edge
//   rst              asynchronous active-low reset
//   coef_we          coefficient write strobe (honoured only while idle)
//   coef_addr        coefficient index k
//   coef_data        coefficient value h[k] (signed)
//   input_valid      a sample is offered
//   input_channel    channel of the offered sample
//   FIR_input        sample value (signed)
//   ready_for_input  block accepts a sample this cycle
//   output_valid     one-cycle strobe, FIR_output / output_channel are new
//   output_channel   channel of FIR_output
//   FIR_output       signed, full-precision filter result
// ---------------------------------------------------------------------------
module fir_filter_mc #(
  parameter  int WIDTH        = 16,
  parameter  int COEF_WIDTH   = 16,
  parameter  int TAPS         = 32,
  parameter  int CHANNELS     = 4,
  localparam int TW           = $clog2(TAPS),
  localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int OUTPUT_WIDTH = WIDTH + COEF_WIDTH + TW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           coef_we,
  input  logic [TW-1:0]                  coef_addr,
  input  logic signed [COEF_WIDTH-1:0]   coef_data,
  input  logic                           input_valid,
  input  logic [CW-1:0]                  input_channel,
  input  logic signed [WIDTH-1:0]        FIR_input,
  output logic                           ready_for_input,
  output logic                           output_valid,
  output logic [CW-1:0]                  output_channel,
  output logic signed [OUTPUT_WIDTH-1:0] FIR_output
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width of one full-precision product.
  localparam int PW = WIDTH + COEF_WIDTH;

  logic [1:0]                     state;
  logic signed [COEF_WIDTH-1:0]   h [TAPS];
  logic signed [WIDTH-1:0]        x [CHANNELS][TAPS];
  logic [CW-1:0]                  ch;
  logic [TW-1:0]                  k;
  logic signed [OUTPUT_WIDTH-1:0] acc;

  logic                           coef_ok;
  logic                           chan_ok;
  logic                           last_tap;
  logic signed [PW-1:0]           x_ext;
  logic signed [PW-1:0]           h_ext;
  logic signed [PW-1:0]           prod;
  logic signed [OUTPUT_WIDTH-1:0] acc_next;

  // NOTE: every signal driven here gets a value before any conditional
  // logic, so no path can leave one unassigned and infer a latch.
  always_comb begin
    ready_for_input = 1'b0;
    if (rst && (state == IDLE) && !coef_we) ready_for_input = 1'b1;

    coef_ok  = int'(coef_addr) < TAPS;
    chan_ok  = int'(input_channel) < CHANNELS;
    last_tap = (k == TW'(TAPS - 1));

    // Size casts keep the operands signed, so both are sign-extended to
    // the product width before the multiply; the product is then exact.
    x_ext    = PW'(x[ch][k]);
    h_ext    = PW'(h[k]);
    prod     = x_ext * h_ext;
    acc_next = acc + OUTPUT_WIDTH'(prod);
  end

  // NOTE: the coefficient table and delay lines are held in flops and are
  // cleared by reset, so a channel restarts from silence after rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ch             <= '0;
      k              <= '0;
      acc            <= '0;
      output_valid   <= 1'b0;
      output_channel <= '0;
      FIR_output     <= '0;
      for (int t = 0; t < TAPS; t++) begin
        h[t] <= '0;
        for (int c = 0; c < CHANNELS; c++) x[c][t] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees
      // the pre-edge value of every other register.
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A coefficient write wins over a sample offered in the same cycle.
          if (coef_we) begin
            if (coef_ok) h[coef_addr] <= coef_data;
          end else if (input_valid && chan_ok) begin
            for (int t = TAPS - 1; t > 0; t--)
              x[input_channel][t] <= x[input_channel][t-1];
            x[input_channel][0] <= FIR_input;
            ch    <= input_channel;
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
          // A sample on a non-existent channel is consumed and dropped.
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (last_tap) state <= DONE;
        end
        DONE: begin
          FIR_output     <= acc;
          output_channel <= ch;
          output_valid   <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// ---------------------------------------------------------------------------
// tb_fir_filter_mc
//
// Two instances: A (TAPS=4, CHANNELS=2) for the main function and B
// (TAPS=3, CHANNELS=3) for out-of-range coefficient address and channel.
// A sample-level model (history per channel, a busy countdown per result)
// predicts every output on every cycle; literal values pin the model.
// ---------------------------------------------------------------------------
module tb_fir_filter_mc;

  logic clk;
  logic rst;

  // Instance A: TAPS=4, CHANNELS=2
  logic               a_coef_we;
  logic [1:0]         a_coef_addr;
  logic signed [15:0] a_coef_data;
  logic               a_iv;
  logic [0:0]         a_ich;
  logic signed [15:0] a_in;
  logic               a_rdy;
  logic               a_ov;
  logic [0:0]         a_och;
  logic signed [33:0] a_fo;

  // Instance B: TAPS=3, CHANNELS=3
  logic               b_coef_we;
  logic [1:0]         b_coef_addr;
  logic signed [15:0] b_coef_data;
  logic               b_iv;
  logic [1:0]         b_ich;
  logic signed [15:0] b_in;
  logic               b_rdy;
  logic               b_ov;
  logic [1:0]         b_och;
  logic signed [33:0] b_fo;

  fir_filter_mc #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(4), .CHANNELS(2)) dut_a (
    .clk(clk), .rst(rst),
    .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
    .input_valid(a_iv), .input_channel(a_ich), .FIR_input(a_in),
    .ready_for_input(a_rdy), .output_valid(a_ov),
    .output_channel(a_och), .FIR_output(a_fo)
  );

  fir_filter_mc #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(3), .CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .input_valid(b_iv), .input_channel(b_ich), .FIR_input(b_in),
    .ready_for_input(b_rdy), .output_valid(b_ov),
    .output_channel(b_och), .FIR_output(b_fo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit run   = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_taps  [2] = '{4, 3};
  int     m_chans [2] = '{2, 3};
  longint m_h     [2][4];
  longint m_x     [2][3][4];   // newest sample at index 0
  int     m_busy  [2];         // edges left until the result is presented
  longint m_pend  [2];
  int     m_pch   [2];
  bit     m_ov    [2];
  longint m_fo    [2];
  int     m_och   [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < 4; t++) begin
        m_h[i][t] = 0;
        for (int c = 0; c < 3; c++) m_x[i][c][t] = 0;
      end
      m_busy[i] = 0; m_pend[i] = 0; m_pch[i] = 0;
      m_ov[i] = 1'b0; m_fo[i] = 0; m_och[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    bit we, iv;
    int addr, ch;
    longint data, val;
    if (i == 0) begin
      we = a_coef_we; addr = int'(a_coef_addr); data = longint'(a_coef_data);
      iv = a_iv; ch = int'(a_ich); val = longint'(a_in);
    end else begin
      we = b_coef_we; addr = int'(b_coef_addr); data = longint'(b_coef_data);
      iv = b_iv; ch = int'(b_ich); val = longint'(b_in);
    end
    m_ov[i] = 1'b0;
    if (m_busy[i] > 0) begin
      m_busy[i]--;
      if (m_busy[i] == 0) begin
        m_ov[i] = 1'b1; m_fo[i] = m_pend[i]; m_och[i] = m_pch[i];
      end
    end else if (we) begin
      if (addr < m_taps[i]) m_h[i][addr] = data;
    end else if (iv && ch < m_chans[i]) begin
      for (int t = m_taps[i] - 1; t > 0; t--) m_x[i][ch][t] = m_x[i][ch][t-1];
      m_x[i][ch][0] = val;
      m_pend[i] = 0;
      for (int t = 0; t < m_taps[i]; t++) m_pend[i] += m_x[i][ch][t] * m_h[i][t];
      m_pch[i]  = ch;
      m_busy[i] = m_taps[i] + 1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_clear();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare + output logs ----------------
  longint qa_fo[$], qb_fo[$];
  int     qa_ch[$], qb_ch[$], qa_cyc[$];

  task automatic cmp(int i);
    bit mrdy;
    if (i == 0) begin
      mrdy = rst && (m_busy[0] == 0) && !a_coef_we;
      check("a_ready", a_rdy, mrdy);
      check("a_valid", a_ov, m_ov[0]);
      check("a_output", longint'(a_fo), m_fo[0]);
      check("a_channel", int'(a_och), m_och[0]);
    end else begin
      mrdy = rst && (m_busy[1] == 0) && !b_coef_we;
      check("b_ready", b_rdy, mrdy);
      check("b_valid", b_ov, m_ov[1]);
      check("b_output", longint'(b_fo), m_fo[1]);
      check("b_channel", int'(b_och), m_och[1]);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp(0);
      cmp(1);
      if (a_ov) begin qa_fo.push_back(longint'(a_fo)); qa_ch.push_back(int'(a_och)); qa_cyc.push_back(cyc); end
      if (b_ov) begin qb_fo.push_back(longint'(b_fo)); qb_ch.push_back(int'(b_och)); end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(int i, bit we, int addr, longint data, bit iv, int ch, longint val);
    if (i == 0) begin
      a_coef_we = we; a_coef_addr = 2'(addr); a_coef_data = 16'(data);
      a_iv = iv; a_ich = 1'(ch); a_in = 16'(val);
    end else begin
      b_coef_we = we; b_coef_addr = 2'(addr); b_coef_data = 16'(data);
      b_iv = iv; b_ich = 2'(ch); b_in = 16'(val);
    end
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while (m_busy[i] != 0 && n < 100) begin tick(); n++; end
    check("idle_within_bound", n < 100, 1);
    @(negedge clk);
    tick();
  endtask

  task automatic wr(int i, int addr, longint data);
    drive(i, 1'b1, addr, data, 1'b0, 0, 0);
    tick();
    drive(i, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic send(int i, int ch, longint val, output int acc_cyc);
    bit r;
    int n = 0;
    drive(i, 1'b0, 0, 0, 1'b1, ch, val);
    do begin
      @(negedge clk);
      r = (i == 0) ? a_rdy : b_rdy;
      tick();
      n++;
    end while (!r && n < 50);
    acc_cyc = cyc;
    check("accept_within_bound", r, 1);
    drive(i, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic clear_logs();
    qa_fo.delete(); qa_ch.delete(); qa_cyc.delete();
    qb_fo.delete(); qb_ch.delete();
  endtask

  // ---------------- directed test ----------------
  int c0, c1, c2, c3, nlog;
  longint exp_imp [4] = '{1, 2, 3, 4};
  longint exp_iso [4] = '{10, 100, 30, 300};
  int     exp_isc [4] = '{0, 1, 0, 1};
  longint exp_h   [4] = '{3, 5, 7, 11};

  initial begin
    rst = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0, 1'b0, 0, 0);
    @(posedge clk);
    run = 1'b1;
    tick(); tick();

    // Reset state
    @(negedge clk);
    check("reset_ready", a_rdy, 0);
    check("reset_valid", a_ov, 0);
    check("reset_output", longint'(a_fo), 0);
    check("reset_channel", int'(a_och), 0);
    check("reset_ready_b", b_rdy, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready_after_reset", a_rdy, 1);
    tick();

    // Impulse, back-to-back on channel 0
    for (int t = 0; t < 4; t++) wr(0, t, t + 1);
    clear_logs();
    send(0, 0, 1, c0);
    send(0, 0, 0, c1);
    send(0, 0, 0, c2);
    send(0, 0, 0, c3);
    wait_idle(0);
    check("impulse_count", qa_fo.size(), 4);
    for (int t = 0; t < 4; t++) begin
      check($sformatf("impulse_out%0d", t), qa_fo[t], exp_imp[t]);
      check($sformatf("impulse_ch%0d", t), qa_ch[t], 0);
    end
    check("latency", qa_cyc[0] - c0, 5);
    check("accept_spacing", c1 - c0, 6);

    // Channel isolation
    for (int t = 0; t < 4; t++) wr(0, t, 1);
    clear_logs();
    send(0, 0, 10, c0);
    send(0, 1, 100, c0);
    send(0, 0, 20, c0);
    send(0, 1, 200, c0);
    wait_idle(0);
    check("iso_count", qa_fo.size(), 4);
    for (int t = 0; t < 4; t++) begin
      check($sformatf("iso_out%0d", t), qa_fo[t], exp_iso[t]);
      check($sformatf("iso_ch%0d", t), qa_ch[t], exp_isc[t]);
    end

    // Extremes
    for (int t = 0; t < 4; t++) wr(0, t, -32768);
    clear_logs();
    for (int t = 0; t < 4; t++) send(0, 0, -32768, c0);
    wait_idle(0);
    check("extreme_count", qa_fo.size(), 4);
    check("extreme_max", qa_fo[3], 64'sd4294967296);
    do_reset();
    for (int t = 0; t < 4; t++) wr(0, t, -32768);
    clear_logs();
    send(0, 0, 32767, c0);
    wait_idle(0);
    check("extreme_neg", qa_fo[0], -64'sd1073709056);

    // Priority of coefficient write, then coef_we ignored during MAC
    do_reset();
    clear_logs();
    drive(0, 1'b1, 0, 5, 1'b1, 0, 7);
    @(negedge clk);
    check("priority_ready_low", a_rdy, 0);
    tick();
    send(0, 0, 7, c0);
    wait_idle(0);
    send(0, 1, 2, c0);
    drive(0, 1'b1, 1, 99, 1'b0, 0, 0);
    tick();
    drive(0, 1'b0, 0, 0, 1'b0, 0, 0);
    wait_idle(0);
    send(0, 1, 0, c0);
    wait_idle(0);
    check("prio_count", qa_fo.size(), 3);
    check("prio_written", qa_fo[0], 35);
    check("mac_write_first", qa_fo[1], 10);
    check("mac_write_ignored", qa_fo[2], 0);

    // Instance B: coefficient address >= TAPS and channel >= CHANNELS
    wr(1, 0, 1); wr(1, 1, 1); wr(1, 2, 1); wr(1, 3, 77);
    send(1, 3, 500, c0);
    tick(); tick(); tick();
    check("bad_channel_no_output", qb_fo.size(), 0);
    check("bad_channel_ready", b_rdy, 1);
    send(1, 0, 9, c0);
    wait_idle(1);
    send(1, 2, 1, c0);
    wait_idle(1);
    send(1, 0, 2, c0);
    wait_idle(1);
    check("b_count", qb_fo.size(), 3);
    check("b_out0", qb_fo[0], 9);
    check("b_out1", qb_fo[1], 1);
    check("b_ch1", qb_ch[1], 2);
    check("b_out2", qb_fo[2], 11);

    // Reset mid-MAC
    for (int t = 0; t < 4; t++) wr(0, t, exp_h[t]);
    clear_logs();
    send(0, 0, 4, c0);
    wait_idle(0);
    check("pre_reset_out", qa_fo[0], 47);
    send(0, 0, 4, c0);
    tick(); tick();
    nlog = qa_fo.size();
    rst = 1'b0;
    #1;
    check("midmac_output_cleared", longint'(a_fo), 0);
    check("midmac_valid_low", a_ov, 0);
    check("midmac_ready_low", a_rdy, 0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("midmac_no_output", qa_fo.size(), nlog);
    for (int t = 0; t < 4; t++) wr(0, t, exp_h[t]);
    clear_logs();
    for (int t = 0; t < 4; t++) send(0, 0, (t == 0) ? 1 : 0, c0);
    wait_idle(0);
    check("post_reset_count", qa_fo.size(), 4);
    for (int t = 0; t < 4; t++)
      check($sformatf("post_reset_out%0d", t), qa_fo[t], exp_h[t]);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
